// File: rtl/cpu_arith_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cpu_arith_pkg                                                 |
// | Brief    : Shared types and constants for the multiplier and divider.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package cpu_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } arith_state_t;

    localparam int c_default_width = 32;

    // Bits needed to hold an iteration count running from width down to 0.
    function automatic int count_bits(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int c_count_width = count_bits(c_default_width);

endpackage : cpu_arith_pkg
`default_nettype wire

// File: rtl/mult_booth_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mult_booth_if                                                 |
// | Brief    : Request/result bundle between a requester and mult_booth.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface mult_booth_if
    import cpu_arith_pkg::*;
#(
    parameter int WIDTH = c_default_width
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, a, b,
        output busy, done, hi, lo
    );

endinterface : mult_booth_if
`default_nettype wire

// File: rtl/booth_step.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : booth_step                                                    |
// | Brief    : One radix-2 Booth iteration: add/sub of M, then arith shift.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module booth_step
    import cpu_arith_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] q,
    input  logic             q_1,
    input  logic [WIDTH:0]   m,
    output logic [WIDTH:0]   acc_next,
    output logic [WIDTH-1:0] q_next,
    output logic             q_1_next
);

    logic [WIDTH:0] w_sum;

    always_comb begin
        w_sum = acc;
        case ({q[0], q_1})
            2'b01:   w_sum = acc + m;
            2'b10:   w_sum = acc - m;
            default: w_sum = acc;
        endcase
    end

    // Arithmetic right shift of the concatenation {sum, q, q_1}.
    assign acc_next = {w_sum[WIDTH], w_sum[WIDTH:1]};
    assign q_next   = {w_sum[0], q[WIDTH-1:1]};
    assign q_1_next = q[0];

endmodule : booth_step
`default_nettype wire

// File: rtl/mult_booth.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mult_booth                                                    |
// | Brief    : Sequential signed radix-2 Booth multiplier, WIDTH+1 latency.  |
// |            Define MULT_ZERO_SKIP_EN to short-cut zero operands to DONE.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mult_booth
    import cpu_arith_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  wire          clk,
    input  wire          reset,
    mult_booth_if.slave  bus
);

    localparam int COUNT_W = (count_bits(WIDTH) > c_count_width) ? count_bits(WIDTH)
                                                                 : c_count_width;

    arith_state_t      r_state;
    arith_state_t      w_state_next;

    logic [WIDTH:0]    r_acc;
    logic [WIDTH-1:0]  r_q;
    logic              r_q_1;
    logic [WIDTH:0]    r_m;
    logic [COUNT_W-1:0] r_count;
    logic [WIDTH-1:0]  r_hi;
    logic [WIDTH-1:0]  r_lo;

    logic [WIDTH:0]    w_acc_next;
    logic [WIDTH-1:0]  w_q_next;
    logic              w_q_1_next;
    logic              w_last_step;
    logic              w_zero_skip;

`ifdef MULT_ZERO_SKIP_EN
    assign w_zero_skip = (bus.a == '0) || (bus.b == '0);
`else
    assign w_zero_skip = 1'b0;
`endif

    assign w_last_step = (r_count == COUNT_W'(1));

    booth_step #(
        .WIDTH    (WIDTH)
    ) u_booth_step (
        .acc      (r_acc),
        .q        (r_q),
        .q_1      (r_q_1),
        .m        (r_m),
        .acc_next (w_acc_next),
        .q_next   (w_q_next),
        .q_1_next (w_q_1_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_next = w_zero_skip ? DONE : CALC;
                end
            end
            CALC: begin
                if (w_last_step) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc   <= '0;
            r_q     <= '0;
            r_q_1   <= 1'b0;
            r_m     <= '0;
            r_count <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start && w_zero_skip) begin
                        r_hi <= '0;
                        r_lo <= '0;
                    end else if (bus.start) begin
                        r_m     <= {bus.a[WIDTH-1], bus.a};
                        r_acc   <= '0;
                        r_q     <= bus.b;
                        r_q_1   <= 1'b0;
                        r_count <= COUNT_W'(WIDTH);
                    end
                end
                CALC: begin
                    r_acc   <= w_acc_next;
                    r_q     <= w_q_next;
                    r_q_1   <= w_q_1_next;
                    r_count <= r_count - COUNT_W'(1);
                    // The final step's shifted {A,Q} is the product; capture it directly.
                    if (w_last_step) begin
                        r_hi <= w_acc_next[WIDTH-1:0];
                        r_lo <= w_q_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy = (r_state == CALC);
    assign bus.done = (r_state == DONE);
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule : mult_booth
`default_nettype wire

// File: tb/tb_mult_booth.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mult_booth                                                 |
// | Brief    : Scoreboard bench for mult_booth at WIDTH=32.                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_mult_booth;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } result_t;

`ifdef MULT_ZERO_SKIP_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 33;
`endif

    logic clk;
    logic reset;

    mult_booth_if #(.WIDTH(32)) bus ();

    mult_booth #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    result_t     sb[$];
    int          vectors;
    int          miscompares;
    logic [31:0] last_hi;
    logic [31:0] last_lo;

    task automatic push_exp(input logic [31:0] h, input logic [31:0] l);
        result_t r;
        r.hi = h;
        r.lo = l;
        sb.push_back(r);
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        #3;
        vectors += 4;
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", bus.done); end
        if (bus.hi !== 32'h0) begin miscompares++; $display("FAIL reset_hi got %h want 0", bus.hi); end
        if (bus.lo !== 32'h0) begin miscompares++; $display("FAIL reset_lo got %h want 0", bus.lo); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset   = 1'b1;
        last_hi = '0;
        last_lo = '0;
    endtask

    task automatic run_mult(input logic [31:0] a_in, input logic [31:0] b_in,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                            input int exp_lat, input string name);
        result_t r;
        int      edges;
        bit      seen;
        @(negedge clk);
        bus.a     = a_in;
        bus.b     = b_in;
        bus.start = 1'b1;
        push_exp(exp_hi, exp_lo);
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 100) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (edges == 1) begin
                bus.start = 1'b0;
                bus.a     = $urandom;
                bus.b     = $urandom;
                vectors++;
                if (bus.busy !== (exp_lat > 1)) begin
                    miscompares++;
                    $display("FAIL %s busy got %b want %b", name, bus.busy, exp_lat > 1);
                end
                if (exp_lat > 1) begin
                    vectors++;
                    if (bus.hi !== last_hi || bus.lo !== last_lo) begin
                        miscompares++;
                        $display("FAIL %s hold got %h_%h want %h_%h", name, bus.hi, bus.lo, last_hi, last_lo);
                    end
                end
            end
            if (bus.done) begin
                seen = 1'b1;
                r = sb.pop_front();
                vectors += 3;
                if (bus.hi !== r.hi) begin miscompares++; $display("FAIL %s hi got %h want %h", name, bus.hi, r.hi); end
                if (bus.lo !== r.lo) begin miscompares++; $display("FAIL %s lo got %h want %h", name, bus.lo, r.lo); end
                if (edges != exp_lat) begin miscompares++; $display("FAIL %s latency got %0d want %0d", name, edges, exp_lat); end
                last_hi = r.hi;
                last_lo = r.lo;
            end
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL %s timeout got no done want done at %0d", name, exp_lat);
            if (sb.size() > 0) r = sb.pop_front();
        end else begin
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                miscompares++;
                $display("FAIL %s done_pulse got done=%b busy=%b want 0/0", name, bus.done, bus.busy);
            end
        end
    endtask

    task automatic test_directed();
        run_mult(32'd7, 32'd6, 32'h0000_0000, 32'h0000_002A, 33, "seven_six");
        run_mult(32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 33, "neg3_5");
        run_mult(32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 33, "min_min");
        run_mult(32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, 33, "max_min");
    endtask

    task automatic test_random();
        logic [31:0] ra, rb;
        longint      p;
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            p  = longint'($signed(ra)) * longint'($signed(rb));
            run_mult(ra, rb, p[63:32], p[31:0], 33, "random");
        end
    endtask

    task automatic test_zero();
        run_mult(32'h0, 32'h1234_5678, 32'h0, 32'h0, ZERO_LAT, "zero_a");
    endtask

    task automatic test_back_to_back();
        result_t r;
        int      e;
        int      pulses;
        int      first_at;
        int      second_at;
        @(negedge clk);
        bus.a     = 32'd5;
        bus.b     = 32'd9;
        bus.start = 1'b1;
        push_exp(32'h0, 32'd45);
        pulses    = 0;
        first_at  = 0;
        second_at = 0;
        e         = 0;
        while (e < 80 && pulses < 2) begin
            @(posedge clk);
            e++;
            @(negedge clk);
            if (e == 1) begin
                bus.a = 32'd11;
                bus.b = 32'hFFFF_FFFC;
                push_exp(32'hFFFF_FFFF, 32'hFFFF_FFD4);
            end
            if (e == 34) begin
                vectors++;
                if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL b2b_idle_busy got %b want 0", bus.busy); end
            end
            if (e == 35) begin
                vectors++;
                if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL b2b_reaccept_busy got %b want 1", bus.busy); end
                bus.start = 1'b0;
            end
            if (bus.done) begin
                pulses++;
                if (pulses == 1) first_at = e; else second_at = e;
                r = sb.pop_front();
                vectors += 2;
                if (bus.hi !== r.hi) begin miscompares++; $display("FAIL b2b_hi got %h want %h", bus.hi, r.hi); end
                if (bus.lo !== r.lo) begin miscompares++; $display("FAIL b2b_lo got %h want %h", bus.lo, r.lo); end
                last_hi = r.hi;
                last_lo = r.lo;
            end
        end
        bus.start = 1'b0;
        vectors += 3;
        if (pulses != 2) begin miscompares++; $display("FAIL b2b_pulses got %0d want 2", pulses); end
        if (first_at != 33) begin miscompares++; $display("FAIL b2b_first_at got %0d want 33", first_at); end
        if (second_at != 67) begin miscompares++; $display("FAIL b2b_second_at got %0d want 67", second_at); end
        while (sb.size() > 0) r = sb.pop_front();
    endtask

    task automatic test_reset_abort();
        int dones;
        @(negedge clk);
        bus.a     = 32'h0000_1234;
        bus.b     = 32'h0000_5678;
        bus.start = 1'b1;
        for (int e = 1; e <= 11; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e == 1) bus.start = 1'b0;
        end
        reset = 1'b0;
        #1;
        vectors += 4;
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got %b want 0", bus.busy); end
        if (bus.done !== 1'b0) begin miscompares++; $display("FAIL abort_done got %b want 0", bus.done); end
        if (bus.hi !== 32'h0) begin miscompares++; $display("FAIL abort_hi got %h want 0", bus.hi); end
        if (bus.lo !== 32'h0) begin miscompares++; $display("FAIL abort_lo got %h want 0", bus.lo); end
        dones = 0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) dones++;
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (bus.done) dones++;
        vectors += 2;
        if (dones != 0) begin miscompares++; $display("FAIL abort_no_done got %0d want 0", dones); end
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL release_idle_busy got %b want 0", bus.busy); end
        last_hi = '0;
        last_lo = '0;
        run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 33, "neg1_sq");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_directed();
        test_zero();
        test_random();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_mult_booth
`default_nettype wire

// File: doc/mult_booth.md
MULT_BOOTH -- requirements
Module: mult_booth

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, request to multiply; sampled only in IDLE.
REQ-005 SHALL have port a, input, WIDTH, signed multiplicand; sampled on the accepting edge.
REQ-006 SHALL have port b, input, WIDTH, signed multiplier; sampled on the accepting edge.
REQ-007 SHALL have port busy, output, 1, high while in CALC.
REQ-008 SHALL have port done, output, 1, one-cycle pulse marking that hi/lo hold a new result.
REQ-009 SHALL have port hi, output, WIDTH, upper half of the signed 2*WIDTH product.
REQ-010 SHALL have port lo, output, WIDTH, lower half of the signed 2*WIDTH product.

Function
REQ-011 SHALL implement the states IDLE, CALC and DONE.
REQ-012 SHALL, in IDLE with start=1, load M=sext(a) to WIDTH+1 bits, A=0 (WIDTH+1 bits), Q=b, Q_1=0 and count=WIDTH, then enter CALC.
REQ-013 SHALL, on each CALC edge, use {Q[0],Q_1}: 01 gives A=A+M; 10 gives A=A-M; 00 and 11 leave A unchanged; an arithmetic right shift of {A,Q,Q_1} by one follows; count is decremented.
REQ-014 SHALL keep A at WIDTH+1 bits so that a = -2^(WIDTH-1) cannot overflow.
REQ-015 SHALL, on the CALC edge where count reaches 0, register hi=A[WIDTH-1:0] and lo=Q, then enter DONE.
REQ-016 SHALL assert done only in DONE, for exactly one cycle; DONE SHALL return to IDLE on the next edge.
REQ-017 SHALL have a latency of WIDTH+1 edges from the accepting edge to done high, which is 33 for WIDTH=32.
REQ-018 SHALL ignore start in CALC and DONE; there is no queuing.
REQ-019 SHALL hold hi/lo stable from one result until the next result is written; start SHALL NOT clear them.
REQ-020 SHALL have a result equal to a*b as a signed 2*WIDTH value for all operand pairs.
REQ-021 SHALL not affect a computation in flight when a or b change after the accepting edge.

Reset
REQ-022 SHALL, while reset=0 and regardless of clk, force state=IDLE, count=0, busy=0, done=0, hi=0, lo=0 and clear A/Q/Q_1/M.
REQ-023 SHALL, on reset assertion mid-CALC, abort the operation, produce no done pulse and write no partial result to hi/lo.
REQ-024 SHALL not accept a start on the first edge after reset release unless start=1 on that edge; IDLE behaves normally from that edge.

Configuration
REQ-025 SHALL, with MULT_ZERO_SKIP_EN defined, go from IDLE directly to DONE when start=1 and (a==0 or b==0), with hi=lo=0 registered and done high 1 edge after acceptance and busy never asserted.
REQ-026 SHALL, without MULT_ZERO_SKIP_EN, treat zero operands like any others, with the full WIDTH+1 edge latency.

Structure
REQ-027 SHALL take the state enum (IDLE/CALC/DONE), the default width constant and the count width from a shared package, cpu_arith_pkg, which is shared with the divider.
REQ-028 SHALL place one Booth step (the add/sub selection plus the arithmetic shift) in a combinational sub-module, booth_step, instantiated once.

Verification
REQ-029 SHALL cover a=7, b=6 -> hi=0x00000000, lo=0x0000002A, with done 33 edges after start.
REQ-030 SHALL cover a=-3 (0xFFFFFFFD), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-031 SHALL cover a=b=0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-032 SHALL cover start held high through CALC, with a/b changed mid-operation -> exactly one done, result from the originally sampled a/b, and the next acceptance only after DONE->IDLE.
REQ-033 SHALL cover reset pulled low at edge 10 of CALC -> hi=lo=0, no done, state IDLE; a fresh start of 0xFFFFFFFF*0xFFFFFFFF -> hi=0, lo=1.
REQ-034 SHALL cover a=0, b=0x12345678 -> hi=lo=0, with done after 1 edge when MULT_ZERO_SKIP_EN is defined and after 33 edges when it is not.
